// File: rtl/count_pkg.sv
// Constants and helpers shared by the upstream counter and the count_capture block.
package count_pkg;

    localparam int CNT_W = 8;

    // Width needed to hold an occupancy of 0..depth inclusive.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/capture_fifo.sv
// Storage and pointers for captured counts. Read/write pointers wrap modulo DEPTH.
// The storage array is not reset; its contents are only visible through data while non-empty.
module capture_fifo
    import count_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       sclr,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic                       full,
    output logic                       empty,
    output logic [level_w(DEPTH)-1:0]  level,
    output logic [W-1:0]               data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (!sclr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (sclr && do_push) mem[wr_ptr] <= din;
    end

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign data  = mem[rd_ptr];

endmodule

// File: rtl/count_capture.sv
// Captures the live counter value on a trigger into a small FIFO with a valid/ready read port.
// Define COUNT_CAPTURE_EDGE_EN to capture on trig rising edges; otherwise every high cycle captures.
module count_capture
    import count_pkg::*;
#(
    parameter int W     = CNT_W,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       sclr,
    input  logic [W-1:0]               cnt_q,
    input  logic                       trig,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [level_w(DEPTH)-1:0]  level,
    output logic                       overflow
);

    logic cap;
    logic pop;
    logic full;
    logic empty;

`ifdef COUNT_CAPTURE_EDGE_EN
    // Edge history holds "trig was low at the previous edge". Clearing it to 0 means a
    // trig that is already high when reset or sclr lifts must drop before it can capture.
    logic trig_low_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)      trig_low_q <= 1'b0;
        else if (!sclr) trig_low_q <= 1'b0;
        else            trig_low_q <= !trig;
    end

    assign cap = trig && trig_low_q;
`else
    assign cap = trig;
`endif

    // Read handshake: out_valid is high whenever an entry is stored and does not depend on
    // out_ready; the head entry is consumed on a rising edge where out_valid && out_ready,
    // and out_data/out_valid hold steady while out_valid && !out_ready.
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)                     overflow <= 1'b0;
        else if (!sclr)                overflow <= 1'b0;
        else if (cap && full && !pop)  overflow <= 1'b1;
    end

    capture_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .clrn  (clrn),
        .sclr  (sclr),
        .push  (cap),
        .pop   (pop),
        .din   (cnt_q),
        .full  (full),
        .empty (empty),
        .level (level),
        .data  (out_data)
    );

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 Parameter W, default 8, width of captured count (matches upstream counter q width).
REQ-002 Parameter DEPTH, default 4, capture FIFO depth in entries; power of two, range 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 sclr  input  1  synchronous clear, active-low; flushes FIFO and flags.
REQ-006 cnt_q  input  W  live count value from upstream counter.
REQ-007 trig  input  1  capture request.
REQ-008 out_valid  output  1  head entry available.
REQ-009 out_ready  input  1  consumer accepts head entry.
REQ-010 out_data  output  W  head entry (captured count).
REQ-011 level  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 overflow  output  1  sticky: capture dropped while full.

Function
REQ-013 Capture event is qualified trig (see Configuration); on the event the module SHALL store cnt_q as sampled at that same rising edge.
REQ-014 Captured entry SHALL be visible on out_data with out_valid=1 one cycle after the capturing edge when FIFO was empty (latency 1, no combinational trig-to-output path).
REQ-015 out_valid SHALL equal (level != 0); out_data SHALL be the oldest entry; out_data is don't-care while out_valid=0.
REQ-016 Pop occurs on a rising edge with out_valid=1 and out_ready=1; out_data/out_valid SHALL not change while out_valid=1 and out_ready=0.
REQ-017 Push and pop in same cycle: level unchanged, both accepted, including when full (pop frees the slot first).
REQ-018 Push while full without pop: entry dropped, FIFO contents unchanged, overflow set to 1 on that edge.
REQ-019 overflow SHALL remain 1 until sclr=0 or clrn=0.
REQ-020 Read/write pointers wrap modulo DEPTH; level SHALL reach exactly DEPTH when full and 0 when empty.
REQ-021 sclr=0 at an edge: level:=0, overflow:=0, pointers:=0, edge history:=0; any push/pop in that cycle SHALL be ignored.
REQ-022 cnt_q wrap (all-ones to zero) SHALL need no special handling; values are stored verbatim.

Reset
REQ-023 clrn=0 SHALL immediately force out_valid=0, level=0, overflow=0, pointers=0, edge history=0, independent of clk.
REQ-024 Storage array SHALL not be reset; contents are unobservable while out_valid=0.
REQ-025 Release of clrn mid-trig SHALL not generate a capture in edge mode until trig is seen low then high.

Configuration
REQ-026 Macro COUNT_CAPTURE_EDGE_EN defined: capture event = rising edge of trig (trig=1 at this edge, registered trig=0 at previous edge); one capture per pulse regardless of width.
REQ-027 COUNT_CAPTURE_EDGE_EN undefined: capture event = trig=1 at each edge (level mode); edge-history register SHALL not be instantiated.

Structure
REQ-028 Shared package count_pkg SHALL hold CNT_W=8 default constant and the level-width function; the counter and this block both import it.
REQ-029 FIFO storage/pointers SHALL be one sub-module, capture_fifo (params W, DEPTH; push, pop, sclr, full, empty, level, data); trig qualification, overflow and handshake logic in the top.

Verification
REQ-030 Reset: clrn=0 for 2 cycles with trig=1 -> out_valid=0, level=0, overflow=0 throughout and 1 cycle after release.
REQ-031 Single capture: cnt_q=8'h17, one-cycle trig, out_ready=0 -> next cycle out_valid=1, out_data=8'h17, level=1, held for 5 cycles; out_ready=1 one cycle -> level=0.
REQ-032 Fill/overflow (DEPTH=4): captures of 8'h01..8'h05, out_ready=0 -> level=4, overflow=1 after 5th, pops return 01,02,03,04 in order.
REQ-033 Full with simultaneous push/pop: FIFO holds 10,11,12,13, capture 8'h14 with out_ready=1 -> overflow stays 0, level=4, subsequent pops 11,12,13,14.
REQ-034 sclr=0 one cycle with level=3, overflow=1, trig=1 -> next cycle level=0, overflow=0, out_valid=0, no capture stored.
REQ-035 Trig held high 4 cycles, cnt_q FE,FF,00,01 -> edge mode: single entry FE; level mode: entries FE,FF,00,01.
